// File: rtl/maze_nav_engine.sv
// ---------------------------------------------------------------------------
// maze_nav_engine
//   Maze game core for a 96x64 RGB565 OLED. Tracks the player cell, moves it
//   on pushbutton presses (wall/edge collision, auto-repeat with a cooldown),
//   performs goal-cell wire cutting and renders the colour of the pixel
//   addressed by (x, y) with one cycle of latency.
//
//   Build option: define MAZE_TRAIL_EN to add a visited-cell register and
//   render visited cells in COL_TRAIL. Undefined, no trail is kept.
//
// Ports
//   basys_clock  in   system clock
//   reset        in   synchronous, active-high
//   pb[4:0]      in   buttons {down, right, left, up, centre}, asynchronous
//   sw           in   per-wire arm switches
//   x, y         in   pixel coordinate from coord_system
//   oled_data    out  RGB565 colour of (x, y), registered
//   wire_to_cut  out  one-hot cut wire, held until reset
//   cut_valid    out  one-cycle pulse when a cut is made
//   player_x/y   out  current player cell
//   done         out  high once a wire has been cut
// ---------------------------------------------------------------------------
module maze_nav_engine #(
    parameter int SCREEN_W    = 96,
    parameter int SCREEN_H    = 64,
    parameter int CELL_LOG2   = 3,
    parameter int GRID_W      = 12,
    parameter int GRID_H      = 8,
    parameter logic [GRID_W*GRID_H-1:0] WALL_MAP = '0,
    parameter int N_WIRES     = 3,
    parameter logic [N_WIRES*8-1:0] GOAL_IDX = {8'd95, 8'd71, 8'd47},
    parameter int START_IDX   = 0,
    parameter int MOVE_PERIOD = 10_000_000,
    parameter logic [15:0] COL_BG     = 16'h0000,
    parameter logic [15:0] COL_WALL   = 16'hFFFF,
    parameter logic [15:0] COL_GOAL   = 16'h07E0,
    parameter logic [15:0] COL_PLAYER = 16'hF800,
    parameter logic [15:0] COL_TRAIL  = 16'h001F,
    localparam int PX_W  = (GRID_W > 1) ? $clog2(GRID_W) : 1,
    localparam int PY_W  = (GRID_H > 1) ? $clog2(GRID_H) : 1
) (
    input  logic                basys_clock,
    input  logic                reset,
    input  logic [4:0]          pb,
    input  logic [N_WIRES-1:0]  sw,
    input  logic [6:0]          x,
    input  logic [5:0]          y,
    output logic [15:0]         oled_data,
    output logic [N_WIRES-1:0]  wire_to_cut,
    output logic                cut_valid,
    output logic [PX_W-1:0]     player_x,
    output logic [PY_W-1:0]     player_y,
    output logic                done
);

    localparam int N_CELLS = GRID_W * GRID_H;
    localparam int IDX_W   = (N_CELLS > 1) ? $clog2(N_CELLS) : 1;
    localparam int CNT_W   = (MOVE_PERIOD > 1) ? $clog2(MOVE_PERIOD) : 1;
    localparam logic [PX_W-1:0] START_X = PX_W'(START_IDX % GRID_W);
    localparam logic [PY_W-1:0] START_Y = PY_W'(START_IDX / GRID_W);

    typedef enum logic [1:0] {
        ST_PLAY,
        ST_HOLD,
        ST_DONE
    } state_t;

    // ---------------------------------------------------------------- state
    state_t               state_q, state_d;
    logic [4:0]           pb_meta_q, pb_sync_q;
    logic [PX_W-1:0]      px_q, px_d;
    logic [PY_W-1:0]      py_q, py_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [N_WIRES-1:0]   cut_q, cut_d;
    logic                 cut_valid_q, cut_valid_d;
    logic                 done_q, done_d;
    logic [15:0]          pix_q, pix_d;
    logic [N_CELLS-1:0]   visited;

`ifdef MAZE_TRAIL_EN
    logic [N_CELLS-1:0]   visited_q, visited_d;
    assign visited = visited_q;
`else
    // No trail is kept; the trail branch of the renderer never fires.
    assign visited = '0;
`endif

    // --------------------------------------------------- movement / cutting
    logic [IDX_W-1:0]     cur_idx;
    logic [IDX_W-1:0]     tgt_idx;
    logic [PX_W-1:0]      tgt_x;
    logic [PY_W-1:0]      tgt_y;
    logic                 tgt_valid;
    logic                 goal_hit;
    logic [N_WIRES-1:0]   goal_sel;

    assign cur_idx = IDX_W'(int'(py_q) * GRID_W + int'(px_q));
    assign tgt_idx = IDX_W'(int'(tgt_y) * GRID_W + int'(tgt_x));

    always_comb begin
        state_d     = state_q;
        px_d        = px_q;
        py_d        = py_q;
        cnt_d       = cnt_q;
        cut_d       = cut_q;
        cut_valid_d = 1'b0;
        done_d      = done_q;
`ifdef MAZE_TRAIL_EN
        visited_d   = visited_q;
`endif
        tgt_x       = px_q;
        tgt_y       = py_q;
        tgt_valid   = 1'b0;
        goal_hit    = 1'b0;
        goal_sel    = '0;

        // Lowest-numbered armed goal matching the current cell wins.
        for (int k = 0; k < N_WIRES; k++) begin
            if (!goal_hit && sw[k] &&
                int'(cur_idx) == int'(GOAL_IDX[k*8 +: 8])) begin
                goal_hit = 1'b1;
                goal_sel = N_WIRES'(1) << k;
            end
        end

        // Adjacent target, direction priority up > down > left > right;
        // tgt_valid stays low when the step would leave the grid.
        if (pb_sync_q[1]) begin
            if (py_q != '0) begin
                tgt_y     = py_q - 1'b1;
                tgt_valid = 1'b1;
            end
        end else if (pb_sync_q[4]) begin
            if (py_q != PY_W'(GRID_H - 1)) begin
                tgt_y     = py_q + 1'b1;
                tgt_valid = 1'b1;
            end
        end else if (pb_sync_q[2]) begin
            if (px_q != '0) begin
                tgt_x     = px_q - 1'b1;
                tgt_valid = 1'b1;
            end
        end else if (pb_sync_q[3]) begin
            if (px_q != PX_W'(GRID_W - 1)) begin
                tgt_x     = px_q + 1'b1;
                tgt_valid = 1'b1;
            end
        end

        case (state_q)
            ST_PLAY: begin
                if (pb_sync_q[0]) begin
                    // Centre press shadows any direction held with it.
                    if (goal_hit) begin
                        cut_d       = goal_sel;
                        cut_valid_d = 1'b1;
                        done_d      = 1'b1;
                        state_d     = ST_DONE;
                    end
                end else if (tgt_valid && !WALL_MAP[tgt_idx]) begin
                    px_d    = tgt_x;
                    py_d    = tgt_y;
                    cnt_d   = CNT_W'(MOVE_PERIOD - 1);
                    state_d = ST_HOLD;
`ifdef MAZE_TRAIL_EN
                    visited_d[tgt_idx] = 1'b1;
`endif
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = ST_PLAY;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DONE: begin
                // Terminal until reset.
            end
            default: begin
                state_d = ST_PLAY;
            end
        endcase
    end

    // ------------------------------------------------------------- renderer
    logic [6:0]           cx;
    logic [5:0]           cy;
    logic                 pix_in_grid;
    logic [IDX_W-1:0]     pix_idx;
    logic                 pix_goal;

    assign cx = x >> CELL_LOG2;
    assign cy = y >> CELL_LOG2;
    assign pix_in_grid = (int'(x) < SCREEN_W) && (int'(y) < SCREEN_H) &&
                         (int'(cx) < GRID_W) && (int'(cy) < GRID_H);
    assign pix_idx = IDX_W'(int'(cy) * GRID_W + int'(cx));

    always_comb begin
        pix_goal = 1'b0;
        for (int k = 0; k < N_WIRES; k++) begin
            if (int'(pix_idx) == int'(GOAL_IDX[k*8 +: 8])) begin
                pix_goal = 1'b1;
            end
        end
    end

    always_comb begin
        pix_d = COL_BG;
        if (pix_in_grid) begin
            if (pix_idx == cur_idx) begin
                pix_d = COL_PLAYER;
            end else if (pix_goal) begin
                // Goals win over walls, so a walled goal still shows green.
                pix_d = COL_GOAL;
            end else if (visited[pix_idx]) begin
                pix_d = COL_TRAIL;
            end else if (WALL_MAP[pix_idx]) begin
                pix_d = COL_WALL;
            end
        end
    end

    // ------------------------------------------------------------ registers
    always_ff @(posedge basys_clock) begin
        if (reset) begin
            state_q     <= ST_PLAY;
            pb_meta_q   <= '0;
            pb_sync_q   <= '0;
            px_q        <= START_X;
            py_q        <= START_Y;
            cnt_q       <= '0;
            cut_q       <= '0;
            cut_valid_q <= 1'b0;
            done_q      <= 1'b0;
            pix_q       <= COL_BG;
`ifdef MAZE_TRAIL_EN
            visited_q   <= N_CELLS'(1) << START_IDX;
`endif
        end else begin
            state_q     <= state_d;
            pb_meta_q   <= pb;
            pb_sync_q   <= pb_meta_q;
            px_q        <= px_d;
            py_q        <= py_d;
            cnt_q       <= cnt_d;
            cut_q       <= cut_d;
            cut_valid_q <= cut_valid_d;
            done_q      <= done_d;
            pix_q       <= pix_d;
`ifdef MAZE_TRAIL_EN
            visited_q   <= visited_d;
`endif
        end
    end

    assign oled_data   = pix_q;
    assign wire_to_cut = cut_q;
    assign cut_valid   = cut_valid_q;
    assign player_x    = px_q;
    assign player_y    = py_q;
    assign done        = done_q;

endmodule

// File: tb/tb_maze_nav_engine.sv
// ---------------------------------------------------------------------------
// tb_maze_nav_engine
//   Directed bench for maze_nav_engine with MOVE_PERIOD=4 and a single wall
//   at cell 1 (column 1, row 0). Expected values are hand-derived from the
//   3-cycle press latency and the 5-cycle move repeat.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_maze_nav_engine;

    logic        clk;
    logic        reset;
    logic [4:0]  pb;
    logic [2:0]  sw;
    logic [6:0]  x;
    logic [5:0]  y;
    logic [15:0] oled_data;
    logic [2:0]  wire_to_cut;
    logic        cut_valid;
    logic [3:0]  player_x;
    logic [2:0]  player_y;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;

    maze_nav_engine #(
        .MOVE_PERIOD (4),
        .WALL_MAP    (96'd2)
    ) dut (
        .basys_clock (clk),
        .reset       (reset),
        .pb          (pb),
        .sw          (sw),
        .x           (x),
        .y           (y),
        .oled_data   (oled_data),
        .wire_to_cut (wire_to_cut),
        .cut_valid   (cut_valid),
        .player_x    (player_x),
        .player_y    (player_y),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // One-cycle press, then enough idle cycles to clear the cooldown.
    task automatic move(input int b);
        pb = 5'(1 << b);
        tick();
        pb = '0;
        repeat (8) tick();
    endtask

    task automatic pixel(input string tag, input int px, input int py,
                         input logic [15:0] exp);
        x = 7'(px);
        y = 6'(py);
        tick();
        tick();
        check_eq(tag, 32'(oled_data), 32'(exp));
    endtask

    initial begin
        int e;
        reset = 1'b0;
        pb    = '0;
        sw    = '0;
        x     = '0;
        y     = '0;

        // 1. reset values and rendering
        do_reset();
        repeat (10) tick();
        check_eq("rst_px", 32'(player_x), 0);
        check_eq("rst_py", 32'(player_y), 0);
        check_eq("rst_wire", 32'(wire_to_cut), 0);
        check_eq("rst_done", 32'(done), 0);
        check_eq("rst_cutv", 32'(cut_valid), 0);
        check_eq("pix_player", 32'(oled_data), 32'h F800);
        pixel("pix_wall", 8, 0, 16'hFFFF);
        pixel("pix_goal47", 88, 24, 16'h07E0);
        pixel("pix_goal95", 95, 63, 16'h07E0);
        pixel("pix_bg", 16, 0, 16'h0000);
        pixel("pix_offgrid", 100, 0, 16'h0000);

        // 3. blocked moves leave the player in PLAY
        pb = 5'b00010;  // up at row 0
        tick();
        pb = 5'b00100;  // left at column 0
        tick();
        pb = 5'b10000;  // down, accepted straight away
        tick();
        pb = '0;
        tick();
        check_eq("blk_x", 32'(player_x), 0);
        check_eq("blk_y", 32'(player_y), 0);
        tick();
        check_eq("down_immediate", 32'(player_y), 1);
        repeat (6) tick();
        move(1);
        check_eq("back_up", 32'(player_y), 0);
        move(3);
        check_eq("wall_right", 32'(player_x), 0);

        // 2. auto-repeat on row 1: moves at cycles 3, 8, 13, 18
        move(4);
        check_eq("row1", 32'(player_y), 1);
        pb = 5'b01000;
        for (int n = 1; n <= 25; n++) begin
            if (n == 21) pb = '0;
            tick();
            e = (n < 3) ? 0 : ((n - 3) / 5 + 1);
            if (e > 4) e = 4;
            check_eq($sformatf("rep_x_c%0d", n), 32'(player_x), 32'(e));
        end
        check_eq("rep_y", 32'(player_y), 1);

        // 4/5. walk to cell 47 (11,3) and cut
        move(4);
        move(4);
        for (int i = 0; i < 7; i++) move(3);
        check_eq("at47_x", 32'(player_x), 11);
        check_eq("at47_y", 32'(player_y), 3);
        pb = 5'b00001;
        tick();
        pb = '0;
        repeat (4) tick();
        check_eq("unarmed_done", 32'(done), 0);
        check_eq("unarmed_wire", 32'(wire_to_cut), 0);
        sw = 3'b001;
        pb = 5'b10001;  // centre + down: centre wins
        tick();
        pb = '0;
        tick();
        check_eq("cut_early", 32'(cut_valid), 0);
        tick();
        check_eq("cut_valid", 32'(cut_valid), 1);
        check_eq("cut_wire", 32'(wire_to_cut), 1);
        check_eq("cut_done", 32'(done), 1);
        check_eq("cut_nomove", 32'(player_y), 3);
        tick();
        check_eq("cut_pulse_end", 32'(cut_valid), 0);
        move(4);
        pb = 5'b00001;
        tick();
        pb = '0;
        repeat (4) tick();
        check_eq("done_y", 32'(player_y), 3);
        check_eq("done_wire", 32'(wire_to_cut), 1);
        check_eq("done_hold", 32'(done), 1);
        check_eq("done_cutv", 32'(cut_valid), 0);

        // 6. reset in the middle of a HOLD
        sw = '0;
        do_reset();
        check_eq("rst2_done", 32'(done), 0);
        check_eq("rst2_wire", 32'(wire_to_cut), 0);
        pb = 5'b10000;
        tick();
        pb = '0;
        tick();
        tick();
        check_eq("hold_move", 32'(player_y), 1);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("hold_rst_x", 32'(player_x), 0);
        check_eq("hold_rst_y", 32'(player_y), 0);
        pb = 5'b10000;
        tick();
        pb = '0;
        tick();
        tick();
        check_eq("post_rst_move", 32'(player_y), 1);
        repeat (6) tick();
`ifdef MAZE_TRAIL_EN
        pixel("trail_start", 0, 0, 16'h001F);
`else
        pixel("no_trail", 0, 0, 16'h0000);
`endif
        pixel("pix_player2", 0, 8, 16'hF800);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
